// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trig strobe into a HOLD_CYCLES-wide level on z, then enforces a GAP_CYCLES
// dead time. Define BEEP_MOD_EN to modulate z with a square wave of half-period BEEP_HALF during hold.
module pulse_stretcher #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned BEEP_HALF   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic stop,
  output logic z,
  output logic busy,
  output logic done
);

  localparam int unsigned CntMax0 = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntMax  = (CntMax0 > 2) ? CntMax0 : 2;
  localparam int unsigned CntW    = $clog2(CntMax);

  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHold = 2'b01,
    StGap  = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            hold_end;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    hold_end = 1'b0;
    case (state_q)
      StIdle: begin
        // stop beats a simultaneous trig
        if (trig && !stop) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end
      end
      StHold: begin
        if (stop) begin
          hold_end = 1'b1;
        end else if (cnt_q == '0) begin
          hold_end = 1'b1;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
        if (hold_end) begin
          if (GAP_CYCLES == 0) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

`ifdef BEEP_MOD_EN
  localparam int unsigned BeepMax = (BEEP_HALF > 2) ? BEEP_HALF : 2;
  localparam int unsigned BeepW   = $clog2(BeepMax);
  localparam logic [BeepW-1:0] BeepLoad = BeepW'(BEEP_HALF - 1);

  logic             phase_q, phase_d;
  logic [BeepW-1:0] bcnt_q, bcnt_d;
  logic             hold_entry;

  assign hold_entry = (state_q == StIdle) && trig && !stop;

  always_comb begin
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    if (hold_entry) begin
      phase_d = 1'b1;
      bcnt_d  = BeepLoad;
    end else if (state_q == StHold) begin
      if (bcnt_q == '0) begin
        phase_d = ~phase_q;
        bcnt_d  = BeepLoad;
      end else begin
        bcnt_d = bcnt_q - BeepW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign z = (state_q == StHold) & phase_q;
`else
  assign z = (state_q == StHold);
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher at default parameters; expected {z,busy,done} per cycle is queued
// as stimulus is driven and checked after the following rising edge.
module tb_pulse_stretcher;

  localparam int unsigned Hold = 16;
  localparam int unsigned Gap  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;
  logic stop = 1'b0;
  logic z, busy, done;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] exp_q[$];
  string      tag_q[$];

  pulse_stretcher #(
    .HOLD_CYCLES(Hold),
    .GAP_CYCLES (Gap),
    .BEEP_HALF  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .trig(trig),
    .stop(stop),
    .z   (z),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Expected z in the k-th hold cycle (k from 0)
  function automatic logic hold_z(input int k);
`ifdef BEEP_MOD_EN
    return ((k / 2) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check();
    logic [2:0] exp;
    string      tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    compared++;
    assert ({z, busy, done} === exp) else begin
      mismatched++;
      $error("FAIL %s: {z,busy,done} got %b required %b", tag, {z, busy, done}, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic s, input logic ez, input logic eb, input logic ed,
                     input string tag);
    @(negedge clk);
    trig = t;
    stop = s;
    exp_q.push_back({ez, eb, ed});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check();
  endtask

  // Natural run; trig is sampled at the first edge, extra trigs optionally injected
  task automatic natural_run(input string tag, input int extra_hold, input int extra_gap);
    cyc(1'b1, 1'b0, hold_z(0), 1'b1, 1'b0, {tag, "_h0"});
    for (int k = 1; k < int'(Hold); k++)
      cyc(k == extra_hold, 1'b0, hold_z(k), 1'b1, 1'b0, $sformatf("%s_h%0d", tag, k));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {tag, "_done"});
    for (int k = 1; k < int'(Gap); k++)
      cyc(k == extra_gap, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("%s_g%0d", tag, k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_idle"});
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_idle2"});
  endtask

  initial begin
    #2;
    exp_q.push_back(3'b000);
    tag_q.push_back("rst_init");
    check();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_after_init");

    // Asynchronous reset mid-hold, then trig present right at release
    cyc(1'b1, 1'b0, hold_z(0), 1'b1, 1'b0, "pre_rst_h0");
    for (int k = 1; k < 6; k++)
      cyc(1'b0, 1'b0, hold_z(k), 1'b1, 1'b0, $sformatf("pre_rst_h%0d", k));
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(3'b000);
    tag_q.push_back("rst_async");
    check();
    @(negedge clk);
    trig = 1'b1;
    rst  = 1'b0;
    exp_q.push_back({hold_z(0), 1'b1, 1'b0});
    tag_q.push_back("trig_at_release");
    @(posedge clk);
    #1;
    check();
    for (int k = 1; k < int'(Hold); k++)
      cyc(1'b0, 1'b0, hold_z(k), 1'b1, 1'b0, $sformatf("rel_h%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rel_done");
    for (int k = 1; k < int'(Gap); k++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("rel_g%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rel_idle");

    // Plain natural run, then one with ignored trigs in hold cycle 3 and gap cycle 2
    natural_run("nat", -1, -1);
    natural_run("retrig", 3, 2);

    // Abort in the 5th hold cycle
    cyc(1'b1, 1'b0, hold_z(0), 1'b1, 1'b0, "abort_h0");
    for (int k = 1; k < 5; k++)
      cyc(1'b0, 1'b0, hold_z(k), 1'b1, 1'b0, $sformatf("abort_h%0d", k));
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "abort_stop");
    for (int k = 1; k < int'(Gap); k++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, $sformatf("abort_g%0d", k));
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("abort_idle%0d", k));

    // trig and stop together in idle: stop wins
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "trig_stop_same");
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("trig_stop_idle%0d", k));

    // A lone trig still works afterwards
    natural_run("final", -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
